// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the alu_ctrl sequencer: ALU opcodes, FSM state
// encoding and instruction field positions.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // Instruction layout: [15:13] op, [12:11] rd, [10:9] rs, [8:7] rt, [7:0] imm
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 7;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Ops that retire a value into rd (NOP and illegal do not).
  function automatic logic writes_rd(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LDI: return 1'b1;
      OP_NOP, OP_ILL:                                return 1'b0;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4-entry register file: two combinational operand reads, one debug read,
// one synchronous write; r0 is hardwired to zero when R0_ZERO is set.
module alu_ctrl_regfile #(
  parameter int DATA_W  = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [4];
  logic              wr_en_s;

  assign wr_en_s = we && !(R0_ZERO && (waddr == 2'd0));

  // register storage with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = (R0_ZERO && (raddr_a == 2'd0))  ? {DATA_W{1'b0}} : regs_r[raddr_a];
  assign rdata_b  = (R0_ZERO && (raddr_b == 2'd0))  ? {DATA_W{1'b0}} : regs_r[raddr_b];
  assign dbg_data = (R0_ZERO && (dbg_addr == 2'd0)) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Issue/control sequencer for an external combinational ALU. Optional
// result flags (flag_z, flag_n) are built when ALU_CTRL_FLAGS_EN is defined.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [DATA_W-1:0] alu_in_c,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err_illegal,
  input  logic [1:0]        dbg_addr,
`ifdef ALU_CTRL_FLAGS_EN
  output logic [DATA_W-1:0] dbg_data,
  output logic              flag_z,
  output logic              flag_n
`else
  output logic [DATA_W-1:0] dbg_data
`endif
);

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       instr_r;
  logic [DATA_W-1:0] result_r;

  logic [2:0]        op_s;
  logic [1:0]        rd_s;
  logic [1:0]        rs_s;
  logic [1:0]        rt_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic              wb_we_s;
  logic [DATA_W-1:0] wb_data_s;

  assign op_s  = instr_r[OP_LSB +: 3];
  assign rd_s  = instr_r[RD_LSB +: 2];
  assign rs_s  = instr_r[RS_LSB +: 2];
  assign rt_s  = instr_r[RT_LSB +: 2];
  assign imm_s = DATA_W'(instr_r[IMM_LSB +: IMM_W]);

  assign instr_ready = (state_r == IDLE);
  assign wb_we_s     = (state_r == WB) && writes_rd(op_s);
  assign wb_data_s   = (op_s == OP_LDI) ? imm_s : result_r;

  alu_ctrl_regfile #(
    .DATA_W  (DATA_W),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we_s),
    .waddr    (rd_s),
    .wdata    (wb_data_s),
    .raddr_a  (rs_s),
    .rdata_a  (rs_data_s),
    .raddr_b  (rt_s),
    .rdata_b  (rt_data_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: one instruction in flight, fixed four-cycle loop
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (instr_valid) begin
          state_s = DECODE;
        end else begin
          state_s = IDLE;
        end
      end
      DECODE:  state_s = EXEC;
      EXEC:    state_s = WB;
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath registers: instruction latch, ALU drive, result capture, status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_r     <= 16'h0000;
      alu_op      <= 3'b000;
      alu_in_b    <= {DATA_W{1'b0}};
      alu_in_c    <= {DATA_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      done        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      // done is high exactly during the WB cycle
      done <= (state_r == EXEC);
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
          end
        end
        DECODE: begin
          // Non-ALU ops park alu_op at 000 and leave the operands untouched
          if (is_alu_op(op_s)) begin
            alu_op   <= op_s;
            alu_in_b <= rs_data_s;
            alu_in_c <= rt_data_s;
          end else begin
            alu_op <= OP_ADD;
          end
        end
        EXEC: begin
          result_r <= alu_result;
        end
        WB: begin
          if (op_s == OP_ILL) begin
            err_illegal <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CTRL_FLAGS_EN
  // Result flags follow every value retired into rd (even a dropped r0 write)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (wb_we_s) begin
      flag_z <= (wb_data_s == {DATA_W{1'b0}});
      flag_n <= wb_data_s[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural ALU model.
// Define ALU_CTRL_FLAGS_EN to also exercise flag_z/flag_n.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [2:0]  alu_op;
  logic [7:0]  alu_in_b;
  logic [7:0]  alu_in_c;
  logic [7:0]  alu_result;
  logic        done;
  logic        err_illegal;
  logic [1:0]  dbg_addr = 2'd0;
  logic [7:0]  dbg_data;
`ifdef ALU_CTRL_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ex_op;
  logic [7:0] ex_b;
  logic [7:0] ex_c;

  always #5 clk = ~clk;

  alu_ctrl #(
    .DATA_W  (8),
    .R0_ZERO (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_in_b    (alu_in_b),
    .alu_in_c    (alu_in_c),
    .alu_result  (alu_result),
    .done        (done),
    .err_illegal (err_illegal),
    .dbg_addr    (dbg_addr),
`ifdef ALU_CTRL_FLAGS_EN
    .dbg_data    (dbg_data),
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`else
    .dbg_data    (dbg_data)
`endif
  );

  // behavioural ALU
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000:  alu_result = alu_in_b + alu_in_c;
      3'b001:  alu_result = alu_in_b - alu_in_c;
      3'b010:  alu_result = alu_in_b & alu_in_c;
      3'b011:  alu_result = alu_in_b | alu_in_c;
      3'b100:  alu_result = (alu_in_b < alu_in_c) ? 8'h01 : 8'h00;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 7'b0000000};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b101, rd, 3'b000, imm};
  endfunction

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check_eq(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  // Issue one instruction from IDLE and follow it to the next IDLE
  task automatic run_instr(input string tag, input logic [15:0] ins);
    int waited = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_ready_idle"}, {31'h0, instr_ready}, 32'h1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check_eq({tag, "_ready_decode"}, {31'h0, instr_ready}, 32'h0);
    @(posedge clk); #1;
    ex_op = alu_op;
    ex_b  = alu_in_b;
    ex_c  = alu_in_c;
    check_eq({tag, "_done_exec"}, {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    check_eq({tag, "_done_wb"}, {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    check_eq({tag, "_done_after"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int accepts;
    int dones;
    int ready_bad;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_ready", {31'h0, instr_ready}, 32'h1);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_err", {31'h0, err_illegal}, 32'h0);
    check_eq("rst_alu", {21'h0, alu_op, alu_in_b, alu_in_c}, 32'h0);
    check_reg("rst_r1", 2'd1, 8'h00);

    run_instr("ldi_r1", mk_ldi(2'd1, 8'h05));
    check_reg("ldi_r1_val", 2'd1, 8'h05);
    run_instr("ldi_r2", mk_ldi(2'd2, 8'h03));
    check_reg("ldi_r2_val", 2'd2, 8'h03);

    run_instr("add", mk_r(OP_ADD, 2'd3, 2'd1, 2'd2));
    check_eq("add_exec", {13'h0, ex_op, ex_b, ex_c}, {13'h0, 3'b000, 8'h05, 8'h03});
    check_reg("add_r3", 2'd3, 8'h08);

    run_instr("sub", mk_r(OP_SUB, 2'd3, 2'd2, 2'd1));
    check_eq("sub_exec", {13'h0, ex_op, ex_b, ex_c}, {13'h0, 3'b001, 8'h03, 8'h05});
    check_reg("sub_r3", 2'd3, 8'hFE);
`ifdef ALU_CTRL_FLAGS_EN
    check_eq("sub_flags", {30'h0, flag_z, flag_n}, 32'h1);
`endif

    // Hold valid with SLT r3,r2,r1 for three back-to-back instructions
    accepts = 0; dones = 0; ready_bad = 0;
    instr = mk_r(OP_SLT, 2'd3, 2'd2, 2'd1);
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) accepts++;
      if (done) dones++;
      if (instr_ready !== ((i % 4) == 0)) ready_bad++;
      if (i == 11) instr_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("b2b_accepts", accepts, 32'd3);
    check_eq("b2b_dones", dones, 32'd3);
    check_eq("b2b_ready_pattern", ready_bad, 32'd0);
    check_reg("slt_r3_true", 2'd3, 8'h01);

    run_instr("slt_f", mk_r(OP_SLT, 2'd3, 2'd1, 2'd2));
    check_eq("slt_exec", {13'h0, ex_op, ex_b, ex_c}, {13'h0, 3'b100, 8'h05, 8'h03});
    check_reg("slt_r3_false", 2'd3, 8'h00);

    run_instr("and", mk_r(OP_AND, 2'd3, 2'd1, 2'd2));
    check_reg("and_r3", 2'd3, 8'h01);

    run_instr("ldi_r0", mk_ldi(2'd0, 8'hAA));
    check_eq("ldi_r0_aluop", {29'h0, ex_op}, 32'h0);
    check_reg("ldi_r0_val", 2'd0, 8'h00);

    run_instr("ill", {OP_ILL, 2'd1, 3'b000, 8'h77});
    check_eq("ill_err", {31'h0, err_illegal}, 32'h1);
    check_reg("ill_r1", 2'd1, 8'h05);
    check_reg("ill_r2", 2'd2, 8'h03);
    check_reg("ill_r3", 2'd3, 8'h01);

    run_instr("or", mk_r(OP_OR, 2'd3, 2'd1, 2'd2));
    check_reg("or_r3", 2'd3, 8'h07);
    check_eq("err_sticky", {31'h0, err_illegal}, 32'h1);

`ifdef ALU_CTRL_FLAGS_EN
    run_instr("sub_zero", mk_r(OP_SUB, 2'd3, 2'd1, 2'd1));
    check_reg("sub_zero_r3", 2'd3, 8'h00);
    check_eq("zero_flags", {30'h0, flag_z, flag_n}, 32'h2);
`endif

    // Reset during EXEC of ADD r3,r1,r2 aborts it
    instr = mk_r(OP_ADD, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_in_exec", {31'h0, instr_ready}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", {31'h0, instr_ready}, 32'h1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check_eq("abort_no_done", dones, 32'd0);
    check_eq("abort_err_clr", {31'h0, err_illegal}, 32'h0);
    check_reg("abort_r3", 2'd3, 8'h00);
    check_reg("abort_r1", 2'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
